// File: rtl/pong_sound_pkg.sv
// Shared types and constants for the Pong sound engine: player state,
// channel index width and the millisecond prescaler divisor.
package pong_sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int CH_W = 3;

    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/pong_tone_div.sv
// Square-wave divider: toggles the tone every half_period clocks while enabled.
// load restarts the phase (counter and tone cleared); half_period of 0 acts as 1.
module pong_tone_div #(
    parameter int DIV_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] half_period,
    output logic             tone
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;
    logic [DIV_W-1:0] last;

    always_comb begin
        last   = (half_period == '0) ? '0 : half_period - DIV_W'(1);
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (load || !en) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q >= last) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d  = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/pong_sound_engine.sv
// Multi-channel Pong tone player with priority, pre-emption and pending events.
// Optional SOUND_VOLUME_EN adds a 3-bit volume input gating the tone with 8-step PWM.
module pong_sound_engine
    import pong_sound_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 18,
    parameter int DUR_W  = 8,
    parameter int GAP_MS = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH*DIV_W-1:0] half_period,
    input  logic [NUM_CH*DUR_W-1:0] duration,
`ifdef SOUND_VOLUME_EN
    input  logic [2:0]              volume,
`endif
    output logic                    speaker,
    output logic                    busy,
    output logic [CH_W-1:0]         active_ch
);

    localparam int MS_DIV = ms_div(CLK_HZ);
    localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int GAP_W  = $clog2(GAP_MS + 1);
    localparam int MS_W   = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DIV_W-1:0]    hp_q, hp_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [MS_W-1:0]     ms_q, ms_d;
    logic [PRE_W-1:0]    pre_q, pre_d;

    logic                tick;
    logic [NUM_CH-1:0]   cand;
    logic [CH_W-1:0]     trig_top, cand_top, launch_ch;
    logic                launch, restart;
    logic [DIV_W-1:0]    hp_sel;
    logic [DUR_W-1:0]    dur_sel;
    logic                tone;

    function automatic logic [CH_W-1:0] top_index(input logic [NUM_CH-1:0] v);
        top_index = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) top_index = CH_W'(i);
        end
    endfunction

    function automatic logic [NUM_CH-1:0] ch_mask(input logic [CH_W-1:0] ch);
        ch_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) ch_mask[i] = 1'b1;
        end
    endfunction

    always_comb begin
        tick  = (pre_q == PRE_W'(MS_DIV - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    always_comb begin
        cand     = pending_q | trig;
        trig_top = top_index(trig);
        cand_top = top_index(cand);
        launch    = 1'b0;
        launch_ch = cand_top;
        restart   = 1'b0;
        state_d   = state_q;
        pending_d = pending_q;
        ch_d      = ch_q;
        hp_d      = hp_q;
        dur_d     = dur_q;
        ms_d      = ms_q;

        case (state_q)
            IDLE: begin
                pending_d = cand;
                if (|cand) launch = 1'b1;
            end
            PLAY: begin
                // A retrigger of the playing channel never queues itself.
                pending_d = pending_q | (trig & ~ch_mask(ch_q));
                if ((|trig) && (trig_top > ch_q)) begin
                    launch    = 1'b1;
                    launch_ch = trig_top;
                end else if (|(trig & ch_mask(ch_q))) begin
                    restart = 1'b1;
                    ms_d    = MS_W'(dur_q);
                end else if (tick) begin
                    if (ms_q <= MS_W'(1)) begin
                        state_d = GAP;
                        ms_d    = MS_W'(GAP_MS);
                    end else begin
                        ms_d    = ms_q - MS_W'(1);
                    end
                end
            end
            GAP: begin
                pending_d = cand;
                if (tick) begin
                    if (ms_q <= MS_W'(1)) begin
                        state_d = IDLE;
                        ms_d    = '0;
                    end else begin
                        ms_d    = ms_q - MS_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        hp_sel  = '0;
        dur_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (launch_ch == CH_W'(i)) begin
                hp_sel  = half_period[i*DIV_W +: DIV_W];
                dur_sel = duration[i*DUR_W +: DUR_W];
            end
        end

        if (launch) begin
            state_d   = PLAY;
            ch_d      = launch_ch;
            hp_d      = hp_sel;
            dur_d     = dur_sel;
            ms_d      = MS_W'(dur_sel);
            pending_d = pending_d & ~ch_mask(launch_ch);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ch_q      <= '0;
            hp_q      <= '0;
            dur_q     <= '0;
            ms_q      <= '0;
            pre_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ch_q      <= ch_d;
            hp_q      <= hp_d;
            dur_q     <= dur_d;
            ms_q      <= ms_d;
            pre_q     <= pre_d;
        end
    end

    pong_tone_div #(
        .DIV_W       (DIV_W)
    ) u_tone_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (launch || restart),
        .en          (state_q == PLAY),
        .half_period (hp_q),
        .tone        (tone)
    );

`ifdef SOUND_VOLUME_EN
    logic [2:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = pwm_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_q <= '0;
        else        pwm_q <= pwm_d;
    end

    assign speaker = tone & (state_q == PLAY) & (pwm_q < volume);
`else
    assign speaker = tone & (state_q == PLAY);
`endif

    assign busy      = (state_q != IDLE);
    assign active_ch = ch_q;

endmodule

// File: tb/tb_pong_sound_engine.sv
// Scoreboard bench for pong_sound_engine: a time-based reference model predicts
// busy/active_ch/speaker every clock; a negedge monitor pops and compares.
module tb_pong_sound_engine;

    localparam int CLK_HZ = 100000;
    localparam int MS_DIV = CLK_HZ / 1000;
    localparam int NUM_CH = 3;
    localparam int DIV_W  = 18;
    localparam int DUR_W  = 8;
    localparam int GAP_MS = 20;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       trig;
    logic [NUM_CH*DIV_W-1:0] half_period;
    logic [NUM_CH*DUR_W-1:0] duration;
    logic                    speaker;
    logic                    busy;
    logic [2:0]              active_ch;
`ifdef SOUND_VOLUME_EN
    logic [2:0]              volume;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 idle, 1 playing, 2 gap.
    int m_state, m_ch, m_pend, m_hp, m_dur, m_left, m_start, m_n;
    logic [4:0] exp_q[$];

    pong_sound_engine #(
        .CLK_HZ      (CLK_HZ),
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DUR_W       (DUR_W),
        .GAP_MS      (GAP_MS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (trig),
        .half_period (half_period),
        .duration    (duration),
`ifdef SOUND_VOLUME_EN
        .volume      (volume),
`endif
        .speaker     (speaker),
        .busy        (busy),
        .active_ch   (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int top_bit(input int v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_CH; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_launch(input int c);
        m_state = 1;
        m_ch    = c;
        m_hp    = int'(half_period[c*DIV_W +: DIV_W]);
        m_dur   = int'(duration[c*DUR_W +: DUR_W]);
        m_left  = (m_dur == 0) ? 1 : m_dur;
        m_start = m_n;
        m_pend  = m_pend & ~(1 << c);
    endtask

    task automatic model_step();
        int t, c, hpe;
        logic spk;
        if (!rst_n) begin
            m_state = 0; m_ch = 0; m_pend = 0; m_hp = 0;
            m_dur = 0; m_left = 0; m_start = 0; m_n = 0;
        end else begin
            m_n++;
            t = int'(trig);
            case (m_state)
                0: begin
                    c = m_pend | t;
                    m_pend = c;
                    if (c != 0) model_launch(top_bit(c));
                end
                1: begin
                    m_pend = m_pend | (t & ~(1 << m_ch));
                    if (t != 0 && top_bit(t) > m_ch) begin
                        model_launch(top_bit(t));
                    end else if (t[m_ch]) begin
                        m_start = m_n;
                        m_left  = (m_dur == 0) ? 1 : m_dur;
                    end else if (m_n % MS_DIV == 0) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_state = 2;
                            m_left  = GAP_MS;
                        end
                    end
                end
                default: begin
                    m_pend = m_pend | t;
                    if (m_n % MS_DIV == 0) begin
                        m_left--;
                        if (m_left == 0) m_state = 0;
                    end
                end
            endcase
        end
        hpe = (m_hp == 0) ? 1 : m_hp;
        spk = (m_state == 1) && ((((m_n - m_start) / hpe) % 2) == 1);
`ifdef SOUND_VOLUME_EN
        spk = spk && ((m_n % 8) < int'(volume));
`endif
        exp_q.push_back({(m_state != 0), 3'(m_ch), spk});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: one comparison per clock, sampled mid-cycle.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!rst_n) e = 5'b0;
                n_checks++;
                if ({busy, active_ch, speaker} !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: busy/ch/spk got %0b/%0d/%0b, required %0b/%0d/%0b",
                             $time, busy, active_ch, speaker, e[4], e[3:1], e[0]);
                end
            end
        end
    end

    task automatic set_cfg(input int c, input int hp, input int dur);
        half_period[c*DIV_W +: DIV_W] = DIV_W'(hp);
        duration[c*DUR_W +: DUR_W]    = DUR_W'(dur);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m);
        @(posedge clk); #1 trig = m;
        @(posedge clk); #1 trig = '0;
    endtask

    task automatic wait_quiet(input int budget);
        int k;
        k = 0;
        while (!(busy == 1'b0 && m_state == 0 && m_pend == 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL wait_quiet: busy=%0b after %0d cycles, required idle", busy, budget);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        trig  = '0;
        half_period = '0;
        duration    = '0;
`ifdef SOUND_VOLUME_EN
        volume = 3'd4;
`endif
        set_cfg(0, 4, 2);
        set_cfg(1, 3, 3);
        set_cfg(2, 6, 1);
        cycles(3);
        rst_n = 1'b1;
        cycles(5);

        // single tone, then simultaneous triggers
        pulse(3'b001);
        wait_quiet(8000);
        pulse(3'b101);
        wait_quiet(12000);

        // pre-emption of ch1 by ch2
        pulse(3'b010);
        cycles(50);
        pulse(3'b100);
        wait_quiet(12000);

        // retrigger of the playing channel
        pulse(3'b010);
        cycles(150);
        pulse(3'b010);
        wait_quiet(12000);

        // lower-priority event during play, higher-priority event during gap
        pulse(3'b100);
        cycles(40);
        pulse(3'b001);
        cycles(300);
        pulse(3'b100);
        wait_quiet(12000);

        // half_period 0, duration 0, config changed mid-tone
        set_cfg(2, 0, 0);
        pulse(3'b100);
        cycles(20);
        set_cfg(2, 9, 5);
        wait_quiet(8000);

        // asynchronous reset while playing with a pending channel
        set_cfg(2, 6, 1);
        pulse(3'b011);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, speaker} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: busy/spk got %0b/%0b, required 0/0", busy, speaker);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(400);

        // randomized episodes
        for (int e = 0; e < 3; e++) begin
            for (int c = 0; c < NUM_CH; c++) set_cfg(c, $urandom_range(0, 9), $urandom_range(0, 2));
`ifdef SOUND_VOLUME_EN
            volume = 3'($urandom_range(0, 7));
`endif
            for (int k = 0; k < 300; k++) begin
                @(posedge clk); #1;
                trig = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
                if ($urandom_range(0, 63) == 0)
                    set_cfg($urandom_range(0, NUM_CH - 1), $urandom_range(0, 9), $urandom_range(0, 2));
            end
            @(posedge clk); #1 trig = '0;
            wait_quiet(15000);
        end

        cycles(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
